vga_timing_gen: RTL
===================

# vga_timing_gen

VGA 640x480@60 Hz timing generator. It produces the `hCount`/`vCount` scan position, `bright` and the sync pulses consumed by the pixel generator (`vga_bitchange`) and the board VGA pins. From the 100 MHz system clock it also derives a 25 MHz pixel enable, a vblank tick and a frame counter for game-logic updates and sprite animation.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per pixel; legal values are 1..16.
- `H_TOTAL`, 800: pixels per line.
- `H_SYNC`, 96: hSync low width, in pixels.
- `H_START`, 144: first visible hCount.
- `H_END`, 784: first hCount after the visible region.
- `V_TOTAL`, 525: lines per frame.
- `V_SYNC`, 2: vSync low width, in lines.
- `V_START`, 35: first visible vCount.
- `V_END`, 515: first vCount after the visible region.

Ports:
- `clk`  in  1  system clock, 100 MHz. This is the only clock.
- `rst_l`  in  1  reset, asynchronous, active-low.
- `hCount`  out  10  horizontal position, 0..H_TOTAL-1.
- `vCount`  out  10  vertical position, 0..V_TOTAL-1.
- `bright`  out  1  high inside the visible window.
- `hSync`  out  1  active-low horizontal sync.
- `vSync`  out  1  active-low vertical sync.
- `pix_en`  out  1  one-clk pulse every CLK_DIV clks; hCount and vCount advance on edges where it is high.
- `vblank_tick`  out  1  one-clk pulse on the last pixel before vblank.
- `frame_tick`  out  1  one-clk pulse on the last pixel of the frame.
- `frame_count`  out  16  frames completed since reset; wraps.

## Operation
- Divider: `div` counts 0..CLK_DIV-1 and wraps. `pix_en` = (div == CLK_DIV-1). When CLK_DIV=1, `pix_en` is constantly 1.
- Horizontal counter: on a `pix_en` edge, `hCount` increments. At H_TOTAL-1 it goes to 0 instead.
- Vertical counter: `vCount` increments only on a `pix_en` edge where `hCount`==H_TOTAL-1. At V_TOTAL-1 it goes to 0 instead.
- `bright`, `hSync` and `vSync` are registered. Each is decoded from the next-state counter values, so it is cycle-aligned with the `hCount`/`vCount` values it describes:
  - `bright` = (H_START <= h < H_END) && (V_START <= v < V_END).
  - `hSync` = !(h < H_SYNC).
  - `vSync` = !(v < V_SYNC).
- `vblank_tick` = pix_en && hCount==H_TOTAL-1 && vCount==V_END-1. It is a combinational decode of registers.
- `frame_tick` = pix_en && hCount==H_TOTAL-1 && vCount==V_TOTAL-1.
- `frame_count` increments by 1 on each `frame_tick` edge and wraps from 0xFFFF to 0.
- The block has no inputs besides clock and reset. It free-runs.

## Timing
- Reset (`rst_l` low, asynchronous) sets:
  - div=0, hCount=0, vCount=0, frame_count=0.
  - bright=0, hSync=0, vSync=0. Position (0,0) lies inside both sync pulses.
  - pix_en, vblank_tick and frame_tick are 0 while in reset, unless CLK_DIV=1, in which case pix_en is 1.
- Reset release is synchronous in effect: the first `pix_en` occurs CLK_DIV-1 clks after the first rising edge with `rst_l` high.
- After reset release, `hCount` reaches 1 on the CLK_DIV-th rising edge.
- Counter-to-output latency is 0. The registered decodes update on the same edge as the counters.
- Pulse widths, at CLK_DIV=4:
  - hSync low for 96 pixels = 384 clks per line.
  - vSync low for 2 lines = 6400 clks.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clks.
- `vblank_tick` and `frame_tick` are never high in the same cycle, because V_END < V_TOTAL.
- Reset asserted mid-line or mid-frame takes effect immediately. There is no partial-frame `frame_tick`.

## Structure
- Shared header `vga_timing.vh` holds the 640x480 defaults listed above. `vga_bitchange` and the game logic use the same constants, for example H_START and V_START as the visible origin.
- One sub-module: `pix_en_gen`, the CLK_DIV divider producing `pix_en`.
- The counters, decode registers and frame counter live in the top module.

## Test plan
- Reset: hold `rst_l` low for 10 clks -> hCount=0, vCount=0, bright=0, hSync=0, vSync=0, frame_count=0. After release, pix_en is first high at clk 3, and hCount=1 after clk 4.
- Divider: over 400 clks -> exactly 100 `pix_en` pulses, each one clk wide.
- Line: hSync low exactly while hCount<96. hCount wraps 799->0 on the edge where vCount goes 0->1.
- Visible window: `bright` is high for exactly 640*480 = 307,200 pixel ticks per frame, and only for hCount 144..783 with vCount 35..514.
- Frame: `vblank_tick` is high once, at (799,514). `frame_tick` is high once, at (799,524). frame_count=1 after 1,680,000 clks. After a forced 0xFFFF the next frame_tick gives 0.
- Mid-frame reset: assert `rst_l` low asynchronously at (400,200) -> all outputs take their reset values within the same cycle, with no `frame_tick`. Also check CLK_DIV=1: pix_en is constant 1 and the frame period is 420,000 clks.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 Hz timing constants and small helpers for the VGA timing generator,
// the pixel generator and the game logic.
package vga_timing_gen_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned FC_W  = 16;

    localparam int unsigned DEF_CLK_DIV = 4;
    localparam int unsigned DEF_H_TOTAL = 800;
    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_START = 144;
    localparam int unsigned DEF_H_END   = 784;
    localparam int unsigned DEF_V_TOTAL = 525;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_START = 35;
    localparam int unsigned DEF_V_END   = 515;

    // Half-open interval test lo <= x < hi on a scan coordinate.
    function automatic logic in_window(
        input logic [CNT_W-1:0] x,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (x >= lo) && (x < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_en_gen.sv
// Pixel-enable divider: one-clock pulse every CLK_DIV system clocks.
// With CLK_DIV=1 the counter is a constant 0 and the pulse is permanently high.
module vga_timing_gen_pix_en_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic pix_en_o
);

    localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Next divider value: wrap after the last phase.
    always_comb begin
        div_d = div_q;
        if (div_q == DIV_LAST) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Divider state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= {DIV_W{1'b0}};
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_en_o = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan timing generator: pixel/line counters, registered bright/sync decodes,
// vblank and frame ticks, and a free-running frame counter.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV,
    parameter int unsigned H_TOTAL = DEF_H_TOTAL,
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_START = DEF_H_START,
    parameter int unsigned H_END   = DEF_H_END,
    parameter int unsigned V_TOTAL = DEF_V_TOTAL,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_START = DEF_V_START,
    parameter int unsigned V_END   = DEF_V_END
) (
    input  logic             clk,
    input  logic             rst_l,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             bright,
    output logic             hSync,
    output logic             vSync,
    output logic             pix_en,
    output logic             vblank_tick,
    output logic             frame_tick,
    output logic [FC_W-1:0]  frame_count
);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS_END = CNT_W'(V_END - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_END);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_START);
    localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_END);

    logic             pix_en_s;
    logic             line_end_s;
    logic             frame_end_s;
    logic             vblank_s;

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             bright_q, bright_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [FC_W-1:0]  fc_q, fc_d;

    vga_timing_gen_pix_en_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_gen (
        .clk_i    (clk),
        .rst_ni   (rst_l),
        .pix_en_o (pix_en_s)
    );

    assign line_end_s  = pix_en_s && (h_q == H_LAST);
    assign frame_end_s = line_end_s && (v_q == V_LAST);
    assign vblank_s    = line_end_s && (v_q == V_VIS_END);

    // Scan position next state: h wraps at line end, v steps only on line end.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en_s) begin
            if (h_q == H_LAST) begin
                h_d = {CNT_W{1'b0}};
                if (v_q == V_LAST) begin
                    v_d = {CNT_W{1'b0}};
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
                v_d = v_q;
            end
        end else begin
            h_d = h_q;
            v_d = v_q;
        end
    end

    // Decodes use next-state counters so the registered flags line up with hCount/vCount.
    always_comb begin
        bright_d = in_window(h_d, H_START_C, H_END_C) && in_window(v_d, V_START_C, V_END_C);
        hsync_d  = !(h_d < H_SYNC_C);
        vsync_d  = !(v_d < V_SYNC_C);
    end

    // Frame counter next state, wrapping naturally at the top of its range.
    always_comb begin
        fc_d = fc_q;
        if (frame_end_s) begin
            fc_d = fc_q + FC_W'(1);
        end else begin
            fc_d = fc_q;
        end
    end

    // Counter, decode and frame-count registers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            h_q      <= {CNT_W{1'b0}};
            v_q      <= {CNT_W{1'b0}};
            bright_q <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            fc_q     <= {FC_W{1'b0}};
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            bright_q <= bright_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            fc_q     <= fc_d;
        end
    end

    assign hCount      = h_q;
    assign vCount      = v_q;
    assign bright      = bright_q;
    assign hSync       = hsync_q;
    assign vSync       = vsync_q;
    assign pix_en      = pix_en_s;
    assign vblank_tick = vblank_s;
    assign frame_tick  = frame_end_s;
    assign frame_count = fc_q;

endmodule
